// File: rtl/sevenseg_scan_n_if.sv
// rtl/sevenseg_scan_n_if.sv - display data in, segment/common drive out for sevenseg_scan_n
interface sevenseg_scan_n_if #(
  parameter int N_DIG = 4
);
  logic                 en;
  logic [4*N_DIG-1:0]   digits;
  logic [N_DIG-1:0]     dp;
  logic                 lzb;
  logic [3:0]           bright;
  logic [N_DIG-1:0]     com;
  logic [7:0]           seg_data;
  logic                 frame_tick;

  // Datapath side: supplies what to show and reads back the pin drive.
  modport master (
    output en, digits, dp, lzb, bright,
    input  com, seg_data, frame_tick
  );

  // Scanner side.
  modport slave (
    input  en, digits, dp, lzb, bright,
    output com, seg_data, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_n.sv
// rtl/sevenseg_scan_n.sv - multiplexed N-digit seven-segment scanner with brightness and blanking
module sevenseg_scan_n #(
  parameter int N_DIG       = 4,
  parameter int DIV         = 2000,
  parameter int COM_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int HEX_EN      = 0
) (
  input  logic               clk,
  input  logic               rst,
  sevenseg_scan_n_if.slave   bus
);

  localparam int BW = $clog2(DIV);
  localparam int SW = $clog2(N_DIG);
  localparam logic [BW-1:0]    BASE_LAST = BW'(DIV - 1);
  localparam logic [SW-1:0]    SEL_LAST  = SW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] COM_IDLE  = (COM_ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  localparam logic [7:0]       SEG_IDLE  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam bit               HEX       = (HEX_EN != 0);

  logic [BW-1:0]      base_q, base_d;
  logic [3:0]         sub_q, sub_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [4*N_DIG-1:0] sh_digits_q, sh_digits_d;
  logic [N_DIG-1:0]   sh_dp_q, sh_dp_d;
  logic               sh_lzb_q, sh_lzb_d;
  logic [N_DIG-1:0]   com_q, com_d;
  logic [7:0]         seg_q, seg_d;
  logic               tick_q, tick_d;

  logic               base_wrap;
  logic               sub_wrap;
  logic               frame_end;

  // Scan counters: base sub-step divider, 16 brightness sub-steps, digit select.
  always_comb begin
    base_wrap = (base_q == BASE_LAST);
    sub_wrap  = base_wrap && (sub_q == 4'hF);
    frame_end = sub_wrap && (sel_q == SEL_LAST);
    base_d    = base_wrap ? '0 : base_q + 1'b1;
    sub_d     = base_wrap ? sub_q + 4'd1 : sub_q;
    sel_d     = sel_q;
    if (sub_wrap) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
  end

  // Shadow latch: live display data is only taken at frame end so a frame never tears.
  always_comb begin
    sh_digits_d = frame_end ? bus.digits : sh_digits_q;
    sh_dp_d     = frame_end ? bus.dp     : sh_dp_q;
    sh_lzb_d    = frame_end ? bus.lzb    : sh_lzb_q;
  end

  logic [N_DIG-1:0] blank;
  logic             zero_run;
  logic [3:0]       nib;
  logic             dp_bit;
  logic             blank_bit;
  logic [6:0]       seg7;
  logic             lit;
  logic [N_DIG-1:0] onehot;
  logic [7:0]       seg_raw;

  // Output decode from next-cycle counter/shadow state so com and seg move with sel.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      zero_run = zero_run && (sh_digits_d[4*i +: 4] == 4'h0);
      blank[i] = sh_lzb_d && zero_run && (i != 0);
    end

    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (sel_d == SW'(i)) begin
        nib       = sh_digits_d[4*i +: 4];
        dp_bit    = sh_dp_d[i];
        blank_bit = blank[i];
      end
    end

    case (nib)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = HEX ? 7'h77 : 7'h00;
      4'hB:    seg7 = HEX ? 7'h7C : 7'h00;
      4'hC:    seg7 = HEX ? 7'h39 : 7'h00;
      4'hD:    seg7 = HEX ? 7'h5E : 7'h00;
      4'hE:    seg7 = HEX ? 7'h79 : 7'h00;
      default: seg7 = HEX ? 7'h71 : 7'h00;
    endcase

    lit     = bus.en && (sub_d <= bus.bright);
    onehot  = '0;
    seg_raw = 8'h00;
    if (lit) begin
      for (int i = 0; i < N_DIG; i++) begin
        onehot[i] = (sel_d == SW'(i));
      end
      seg_raw = {dp_bit, blank_bit ? 7'h00 : seg7};
    end

    com_d  = (COM_ACT_LOW != 0) ? ~onehot  : onehot;
    seg_d  = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
    tick_d = frame_end;
  end

  // State and registered pin drive; reset parks every output inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      sub_q       <= '0;
      sel_q       <= '0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_lzb_q    <= 1'b0;
      com_q       <= COM_IDLE;
      seg_q       <= SEG_IDLE;
      tick_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      sub_q       <= sub_d;
      sel_q       <= sel_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_lzb_q    <= sh_lzb_d;
      com_q       <= com_d;
      seg_q       <= seg_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.com        = com_q;
  assign bus.seg_data   = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb/tb_sevenseg_scan_n.sv - reference-model bench for sevenseg_scan_n, two configurations
module tb_sevenseg_scan_n;

  localparam int NA = 4, DA = 2, PA = 16 * DA * NA;
  localparam int NB = 3, DB = 3, PB = 16 * DB * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_scan_n_if #(.N_DIG(NA)) ifa ();
  sevenseg_scan_n_if #(.N_DIG(NB)) ifb ();

  sevenseg_scan_n #(.N_DIG(NA), .DIV(DA), .COM_ACT_LOW(1), .SEG_ACT_LOW(1), .HEX_EN(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sevenseg_scan_n #(.N_DIG(NB), .DIV(DB), .COM_ACT_LOW(0), .SEG_ACT_LOW(0), .HEX_EN(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_fail = 0;

  int          ta, tb_t;
  logic [31:0] sa_dig, sb_dig;
  logic [7:0]  sa_dp, sb_dp;
  logic        sa_lzb, sb_lzb;

  function automatic void ref_out(input int ndig, input int div, input bit hex, input int t,
                                  input logic [31:0] sdig, input logic [7:0] sdp, input logic slzb,
                                  input logic en, input logic [3:0] bright,
                                  output logic [7:0] onehot, output logic [7:0] seg);
    int p, sel, sub, nib;
    logic [31:0] upper;
    logic [6:0]  code;
    p     = t % (16 * div * ndig);
    sel   = p / (16 * div);
    sub   = (p / div) % 16;
    upper = sdig >> (4 * sel);
    nib   = int'(upper & 32'hF);
    code  = (nib > 9 && !hex) ? 7'h00 : seg_tbl[nib];
    onehot = 8'h00;
    seg    = 8'h00;
    if (en && sub <= int'(bright)) begin
      onehot = 8'(1 << sel);
      seg    = {sdp[sel], (slzb && sel > 0 && upper == 0) ? 7'h00 : code};
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (ta=%0d)", tag, obs, exp, ta);
    end
  endtask

  task automatic step();
    logic       r;
    logic [7:0] oh, sg;
    @(posedge clk);
    r = rst;
    if (r) begin
      ta = 0; tb_t = 0;
      sa_dig = 0; sa_dp = 0; sa_lzb = 0;
      sb_dig = 0; sb_dp = 0; sb_lzb = 0;
    end else begin
      ta++; tb_t++;
      if (ta % PA == 0) begin
        sa_dig = {16'h0, ifa.digits}; sa_dp = {4'h0, ifa.dp}; sa_lzb = ifa.lzb;
      end
      if (tb_t % PB == 0) begin
        sb_dig = {20'h0, ifb.digits}; sb_dp = {5'h0, ifb.dp}; sb_lzb = ifb.lzb;
      end
    end
    #1;
    if (r) begin
      oh = 8'h00; sg = 8'h00;
    end else begin
      ref_out(NA, DA, 1'b1, ta, sa_dig, sa_dp, sa_lzb, ifa.en, ifa.bright, oh, sg);
    end
    chk("a_com",  {28'h0, ifa.com}, {28'h0, ~oh[3:0]});
    chk("a_seg",  {24'h0, ifa.seg_data}, {24'h0, ~sg});
    chk("a_tick", {31'h0, ifa.frame_tick}, {31'h0, (!r && ta % PA == 0)});
    if (r) begin
      oh = 8'h00; sg = 8'h00;
    end else begin
      ref_out(NB, DB, 1'b0, tb_t, sb_dig, sb_dp, sb_lzb, ifb.en, ifb.bright, oh, sg);
    end
    chk("b_com",  {29'h0, ifb.com}, {29'h0, oh[2:0]});
    chk("b_seg",  {24'h0, ifb.seg_data}, {24'h0, sg});
    chk("b_tick", {31'h0, ifb.frame_tick}, {31'h0, (!r && tb_t % PB == 0)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic en, input logic [15:0] dg, input logic [3:0] dpv,
                       input logic lz, input logic [3:0] br);
    ifa.en = en; ifa.digits = dg; ifa.dp = dpv; ifa.lzb = lz; ifa.bright = br;
    ifb.en = en; ifb.digits = dg[11:0]; ifb.dp = dpv[2:0]; ifb.lzb = lz; ifb.bright = br;
  endtask

  initial begin
    drive(1'b1, 16'h4321, 4'h0, 1'b0, 4'd15);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(300);
    run(50);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(300);
    drive(1'b1, 16'h4321, 4'h0, 1'b0, 4'd3);
    run(300);
    drive(1'b1, 16'h4321, 4'h0, 1'b0, 4'd0);
    run(300);
    drive(1'b1, 16'h0050, 4'h0, 1'b1, 4'd15);
    run(300);
    drive(1'b1, 16'h0000, 4'h0, 1'b1, 4'd15);
    run(300);
    drive(1'b1, 16'h0A0A, 4'b0100, 1'b0, 4'd15);
    run(300);
    drive(1'b1, 16'h1234, 4'h0, 1'b0, 4'd15);
    run(200);
    drive(1'b1, 16'h5678, 4'h0, 1'b0, 4'd15);
    run(300);
    drive(1'b0, 16'h5678, 4'h0, 1'b0, 4'd15);
    run(40);
    drive(1'b1, 16'h5678, 4'h0, 1'b0, 4'd15);
    run(200);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        ifa.digits = 16'($urandom); ifa.dp = 4'($urandom); ifa.lzb = 1'($urandom);
        if ($urandom_range(0, 1) == 0) ifa.digits = ifa.digits & 16'h00FF;
        ifb.digits = ifa.digits[11:0]; ifb.dp = ifa.dp[2:0]; ifb.lzb = ifa.lzb;
      end
      if ($urandom_range(0, 29) == 0) begin
        ifa.bright = 4'($urandom); ifb.bright = ifa.bright;
      end
      if ($urandom_range(0, 39) == 0) begin
        ifa.en = ~ifa.en; ifb.en = ifa.en;
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_n.md
# sevenseg_scan_n

Parametrised multiplexed seven-segment display driver for N common-anode or common-cathode digits. It takes a flat bus of BCD or hex nibbles and per-digit decimal points, scans one digit at a time, and adds 16-level per-slot brightness. It also provides leading-zero blanking and a frame-coherent shadow latch. The block sits between the counter/datapath logic and the board's segment and common pins, and is the generalised replacement for the fixed 4-digit scanner.

## Interface
- `N_DIG`, 4: digit count, 2..8; need not be a power of two.
- `DIV`, 2000: clocks per brightness sub-step, ≥ 2. One digit slot is 16·DIV clocks, so 32 000 at the default, which is 1 ms at 32 MHz.
- `COM_ACT_LOW`, 1: 1 means `com` is active-low.
- `SEG_ACT_LOW`, 1: 1 means `seg_data` is active-low.
- `HEX_EN`, 0: 1 decodes nibble values A–F; 0 blanks them.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: display enable. When 0, all commons are inactive; the counters keep running.
- `digits` in 4·N_DIG: nibble i is `digits[4i+3:4i]`. Digit 0 is least significant.
- `dp` in N_DIG: `dp[i]`=1 lights the decimal point of digit i.
- `lzb` in 1: enables leading-zero blanking.
- `bright` in 4: on-time is (bright+1)/16 of each slot.
- `com` out N_DIG: digit commons, one-hot active.
- `seg_data` out 8: {dp, g, f, e, d, c, b, a}.
- `frame_tick` out 1: one-clock pulse per completed frame.

## Operation
- **Counters:**
  - `base` runs 0..DIV-1 and wraps.
  - `sub` runs 0..15 and increments when base==DIV-1.
  - `sel` runs 0..N_DIG-1 and increments when base==DIV-1 && sub==15. It wraps from N_DIG-1 to 0, with no invalid states for non-power-of-two N_DIG.
- **Frame end (FE):** base==DIV-1 && sub==15 && sel==N_DIG-1. On FE, the shadow registers load `digits`, `dp` and `lzb`. Decode always uses the shadow values, never the live inputs, so a value changing mid-frame never tears.
- **Decode (internal active-high):**
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71 when HEX_EN=1; 00 otherwise.
  - Bit 7 = shadow dp[sel].
- **Leading-zero blanking:** when shadow lzb=1, digit i > 0 is blanked (segments 00) if nibble i and every higher nibble are 0. Digit 0 is never blanked. Its dp bit is still driven.
- **Lit condition:** the active common for digit sel is asserted when `en` && sub ≤ bright. Otherwise all commons are inactive and `seg_data` is forced to all-inactive.
- **Polarity:** the output is inverted when the corresponding *_ACT_LOW parameter is 1.
- **Reset (all synchronous):**
  - base, sub and sel go to 0, and the shadows clear to 0.
  - `com` goes to all-inactive (all 1s when COM_ACT_LOW=1).
  - `seg_data` goes to all-inactive (FF when SEG_ACT_LOW=1).
  - `frame_tick` goes to 0.
  - A reset mid-frame takes effect on the next edge and restarts at digit 0, sub 0, with nothing lit until the first post-reset output update.

## Timing
- **Output latency:** `com` and `seg_data` are registered. They reflect the counter, shadow and `en`/`bright` state sampled one clock earlier.
- **frame_tick:** high for exactly the one clock following an FE cycle. The new shadow data first appears on `seg_data` one clock after the shadow loads, i.e. in the frame_tick cycle.
- **Digit transition:** consecutive slots change `sel` on the same edge that updates both `com` and `seg_data`. No cycle shows the new common with the old segments.
- **Inputs:** `digits`/`dp`/`lzb` are only sampled on FE. `bright` and `en` are sampled every clock, so a change takes effect at the next sub-step comparison, one-clock latency.
- **Frame period:** 16·DIV·N_DIG clocks.

## Test plan
1. **Reset:** assert `rst` for 3 clocks mid-scan with defaults → com = 4'b1111, seg_data = 8'hFF, frame_tick = 0. After release, the first lit digit is digit 0.
2. **Scan order, non-power-of-two:** N_DIG=3, DIV=2, bright=15, digits=12'h321, dp=0 → com (active-low) cycles 110, 101, 011, each for 32 clocks. seg_data is ~06, ~5B, ~4F, then the sequence returns to digit 0. frame_tick pulses once every 96 clocks.
3. **Brightness:** DIV=2, bright=3 → within each 32-clock slot the common is active for 8 clocks and then inactive for 24, with seg_data FF while inactive. bright=0 gives 2 active clocks.
4. **Blanking and hex:**
   - lzb=1, digits=16'h0050 → digits 3 and 2 are blank, digit 1 shows ~6D, digit 0 shows ~3F.
   - digits=0 → only digit 0 shows ~3F.
   - HEX_EN=0 with nibble A → blank. HEX_EN=1 → ~77.
   - dp=4'b0100 → bit 7 = 0 only while digit 2 is lit.
5. **Tear-free update:** change `digits` from 16'h1234 to 16'h5678 mid-frame → the old value is displayed until FE. All four digits show the new value starting in the frame_tick cycle.
6. **Enable:** drop `en` for one slot → the next clock shows all commons inactive and the counters keep advancing. Re-raising `en` resumes at the current sel/sub position.
